mul_writeback_stage: RTL and testbench
======================================

Name: mul_writeback_stage

Overview:
- Downstream companion of the pipelined multiplier (fixed-latency, non-stallable, signed/unsigned 32x32 producing hi/lo words and per-word CR fields).
- Tracks each issued multiply through the multiplier latency and selects the hi or lo result.
- Builds the CR0 / XER OV/SO updates for Rc/OE forms.
- Buffers results in a credit-protected FIFO, so a stalled write-back port never drops a result the multiplier cannot hold back.

Parameters:
- DWIDTH, 32, data word width.
- GPR_AW, 5, destination register address width.
- LATENCY, 4, cycles from issue handshake to valid mul_res_*/mul_crf_* (>=1).
- FIFO_DEPTH, 5, result buffer entries; full throughput requires FIFO_DEPTH >= LATENCY+1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  kill all in-flight and buffered operations
- issue_valid  in  1  multiply issued this cycle; operands go to the multiplier in the same cycle
- issue_ready  out  1  stage can accept a result credit
- issue_dest  in  GPR_AW  destination GPR
- issue_sel_hi  in  1  1 = mulhw/mulhwu (hi word), 0 = mullw (lo word)
- issue_rc  in  1  record form, updates CR0
- issue_oe  in  1  overflow-enable form, updates XER OV/SO
- mul_res_hi, mul_res_lo  in  DWIDTH  multiplier product words
- mul_crf_hi, mul_crf_lo  in  Cr_field  multiplier compare fields (lt, gt, eq, ov)
- xer_so_wr  in  1  architectural SO write (mtxer)
- xer_so_wdata  in  1  value for xer_so_wr
- wb_valid  out  1  result available
- wb_ready  in  1  write-back port accepts
- wb_dest  out  GPR_AW  destination GPR
- wb_data  out  DWIDTH  selected result word
- wb_cr_we  out  1  write CR0
- wb_crf  out  Cr_field  CR0 value {lt, gt, eq, so}
- wb_xer_we  out  1  write XER OV/SO
- wb_xer_ov, wb_xer_so  out  1  new OV / SO
- busy  out  1  any entry in flight or buffered

Behaviour:
Issue and credit:
- issue fires on issue_valid & issue_ready.
- issue_ready = !flush & (inflight + fifo_count < FIFO_DEPTH | (wb_valid & wb_ready)).
- issue_valid while !issue_ready is a protocol error; the op is ignored.

Tracking pipeline:
- LATENCY-deep shift register of {valid, dest, sel_hi, rc, oe}.
- An entry issued at cycle t reaches the tail at t+LATENCY, aligned with mul_res_*.
- A tail valid pushes one FIFO entry. A push always succeeds because of the credit check.
- inflight = count of valid shift-register bits.

Result formation at push:
- data = sel_hi ? mul_res_hi : mul_res_lo.
- CR lt/gt/eq come from mul_crf_hi when sel_hi, otherwise from mul_crf_lo.
- ov = oe & !sel_hi & mul_crf_lo.ov.
- SO handling:
  - so_new = so_q | ov.
  - so_q updates to so_new at pop time for OE entries.
  - so_q is also written by xer_so_wr.
  - If xer_so_wr and an OE pop occur in the same cycle, xer_so_wr wins.
- CR so bit = so value effective at pop (so_q | entry ov).
- wb_cr_we = rc. wb_xer_we = oe.

Output and FIFO:
- FIFO head drives the wb_* outputs; pop on wb_valid & wb_ready.
- Simultaneous push and pop keeps the count unchanged.
- Pushing into an empty FIFO makes the entry visible the next cycle (latency issue->wb_valid = LATENCY+1).
- Order is strictly issue order.

Flush:
- Clears all shift-register valid bits and empties the FIFO at the next edge.
- Multiplier outputs arriving later for killed ops are ignored.
- wb_valid is 0 from the cycle after flush. so_q is kept.

Reset:
- Outputs wb_valid=0, wb_data=0, wb_dest=0, wb_crf=0, wb_cr_we=0, wb_xer_we=0, wb_xer_ov=0, wb_xer_so=0, busy=0, issue_ready=1 after the first edge.
- Shift register, FIFO and so_q are cleared.
- Reset mid-operation discards everything in flight.

busy = inflight != 0 | fifo_count != 0.

Optional Feature:
MUL_WB_BYPASS_EN:
- When defined and the FIFO is empty, the tail entry is presented combinationally on wb_* in its arrival cycle (latency LATENCY).
- If wb_ready is high it is consumed without being written to the FIFO; otherwise it is pushed.
- Without the macro, latency is always LATENCY+1 and wb_* are driven only from FIFO registers.

Test Plan:
- Signed lo, no bypass: issue mullw dest=3, product 0xFFFFFFFF_FFFFFFFA with crf_lo.lt=1 at t+4, wb_ready=1 -> wb_valid at t+5, wb_dest=3, wb_data=0xFFFFFFFA, wb_cr_we=0.
- Hi select, record: issue mulhw rc=1 dest=7, product hi=0x00000000, crf_hi.eq=1 -> wb_data=0, wb_crf={0,0,1,so_q=0}, wb_cr_we=1, wb_xer_we=0.
- Overflow sticky: mullwo rc=1, crf_lo.ov=1 -> wb_xer_ov=1, wb_xer_so=1, CR so=1. Next mullwo with ov=0 -> wb_xer_ov=0, wb_xer_so=1. Then xer_so_wr=1 with xer_so_wdata=0 -> SO back to 0.
- Backpressure: wb_ready=0, issue back-to-back -> issue_ready drops after exactly 5 accepted issues. Release wb_ready -> 5 results in order, none lost; issue_ready reasserts in the first pop cycle.
- Flush: 3 ops in flight plus 2 buffered, assert flush 1 cycle -> next cycle wb_valid=0, busy=0, issue_ready=1; no wb_valid during the following LATENCY cycles.
- Bypass (MUL_WB_BYPASS_EN): FIFO empty, wb_ready=1, issue at t -> wb_valid at t+4. With wb_ready=0 at t+4 -> entry held, wb_valid stays 1 until accepted.

Source files
------------

// File: rtl/mul_writeback_stage.sv
// Generic synchronous FIFO with synchronous clear; head is registered storage.
// Latency: a write becomes visible at the head on the following cycle.
// Backpressure: rd_rdy pops the head; writes into a full FIFO are dropped, so the writer must hold a credit.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_vld = (count != '0);
    assign do_rd  = rd_vld & rd_rdy;
    assign do_wr  = wr_vld & (count != CW'(DEPTH));
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= nxt(wr_ptr);
            if (do_rd) rd_ptr <= nxt(rd_ptr);
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end
endmodule

// Multiplier write-back: tracks issued ops, forms GPR/CR0/XER results, buffers them (bypass: MUL_WB_BYPASS_EN).
// Latency: issue to wb_valid is LATENCY+1 cycles, or LATENCY with the bypass when the buffer is empty.
// Backpressure: wb_ready stalls the buffer; issue_ready withholds credits so no multiplier result is ever dropped.
module mul_writeback_stage #(
    parameter int DWIDTH     = 32,
    parameter int GPR_AW     = 5,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [GPR_AW-1:0] issue_dest,
    input  logic              issue_sel_hi,
    input  logic              issue_rc,
    input  logic              issue_oe,
    input  logic [DWIDTH-1:0] mul_res_hi,
    input  logic [DWIDTH-1:0] mul_res_lo,
    input  logic [3:0]        mul_crf_hi,
    input  logic [3:0]        mul_crf_lo,
    input  logic              xer_so_wr,
    input  logic              xer_so_wdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [GPR_AW-1:0] wb_dest,
    output logic [DWIDTH-1:0] wb_data,
    output logic              wb_cr_we,
    output logic [3:0]        wb_crf,
    output logic              wb_xer_we,
    output logic              wb_xer_ov,
    output logic              wb_xer_so,
    output logic              busy
);
    localparam int IW = $clog2(LATENCY + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic              vld;
        logic [GPR_AW-1:0] dest;
        logic              sel_hi;
        logic              rc;
        logic              oe;
    } trk_t;

    typedef struct packed {
        logic [GPR_AW-1:0] dest;
        logic [DWIDTH-1:0] data;
        logic              lt;
        logic              gt;
        logic              eq;
        logic              ov;
        logic              rc;
        logic              oe;
    } ent_t;

    trk_t            sr [LATENCY];
    trk_t            tail;
    ent_t            tail_ent;
    ent_t            fifo_dat;
    ent_t            head;
    logic            head_vld;
    logic            fifo_vld;
    logic            push;
    logic            pop;
    logic            issue_fire;
    logic            so_q;
    logic            so_eff;
    logic [3:0]      crf_sel;
    logic [IW-1:0]   inflight;
    logic [CW-1:0]   fifo_count;
    logic [31:0]     occupancy;
    // Only the lo word can overflow a 32-bit mullwo; the hi-word ov flag is meaningless here.
    logic            unused_crf_hi_ov;

    assign unused_crf_hi_ov = mul_crf_hi[0];
    assign tail             = sr[LATENCY-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) inflight = inflight + IW'(sr[i].vld);
    end

    // Every tracked op plus every buffered result owns one FIFO slot.
    assign occupancy   = 32'(inflight) + 32'(fifo_count);
    assign pop         = head_vld & wb_ready;
    assign issue_ready = ~flush & ((occupancy < 32'(FIFO_DEPTH)) | pop);
    assign issue_fire  = issue_valid & issue_ready;
    assign busy        = (inflight != '0) | (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < LATENCY; i++) sr[i] <= '0;
        end else begin
            sr[0].vld    <= issue_fire;
            sr[0].dest   <= issue_dest;
            sr[0].sel_hi <= issue_sel_hi;
            sr[0].rc     <= issue_rc;
            sr[0].oe     <= issue_oe;
            for (int i = 1; i < LATENCY; i++) sr[i] <= sr[i-1];
        end
    end

    always_comb begin
        crf_sel     = tail.sel_hi ? mul_crf_hi : mul_crf_lo;
        tail_ent    = '0;
        tail_ent.dest = tail.dest;
        tail_ent.data = tail.sel_hi ? mul_res_hi : mul_res_lo;
        tail_ent.lt   = crf_sel[3];
        tail_ent.gt   = crf_sel[2];
        tail_ent.eq   = crf_sel[1];
        tail_ent.ov   = tail.oe & ~tail.sel_hi & mul_crf_lo[0];
        tail_ent.rc   = tail.rc;
        tail_ent.oe   = tail.oe;
    end

`ifdef MUL_WB_BYPASS_EN
    logic byp;
    assign byp      = tail.vld & ~fifo_vld;
    assign head     = byp ? tail_ent : fifo_dat;
    assign head_vld = fifo_vld | tail.vld;
    assign push     = tail.vld & ~(byp & wb_ready);
`else
    assign head     = fifo_dat;
    assign head_vld = fifo_vld;
    assign push     = tail.vld;
`endif

    fifo #(
        .WIDTH($bits(ent_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .clr    (flush),
        .wr_vld (push),
        .wr_dat (tail_ent),
        .rd_vld (fifo_vld),
        .rd_rdy (wb_ready),
        .rd_dat (fifo_dat),
        .count  (fifo_count)
    );

    // SO is sticky and only advances when the OE result actually retires; mtxer overrides.
    assign so_eff = so_q | head.ov;

    always_ff @(posedge clk) begin
        if (reset) begin
            so_q <= 1'b0;
        end else if (xer_so_wr) begin
            so_q <= xer_so_wdata;
        end else if (pop && head.oe) begin
            so_q <= so_eff;
        end
    end

    always_comb begin
        wb_valid  = head_vld;
        wb_dest   = '0;
        wb_data   = '0;
        wb_crf    = '0;
        wb_cr_we  = 1'b0;
        wb_xer_we = 1'b0;
        wb_xer_ov = 1'b0;
        wb_xer_so = 1'b0;
        if (head_vld) begin
            wb_dest   = head.dest;
            wb_data   = head.data;
            wb_crf    = {head.lt, head.gt, head.eq, so_eff};
            wb_cr_we  = head.rc;
            wb_xer_we = head.oe;
            wb_xer_ov = head.ov;
            wb_xer_so = so_eff;
        end
    end
endmodule

// File: tb/tb_mul_writeback_stage.sv
// Directed bench for mul_writeback_stage: issue side pushes expected write-backs, a negedge monitor checks them.
module tb_mul_writeback_stage;
    localparam int LAT = 4;
`ifdef MUL_WB_BYPASS_EN
    localparam int EXP_LAT = LAT;
`else
    localparam int EXP_LAT = LAT + 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [4:0]  issue_dest = '0;
    logic        issue_sel_hi = 1'b0;
    logic        issue_rc = 1'b0;
    logic        issue_oe = 1'b0;
    logic [31:0] mul_res_hi = '0;
    logic [31:0] mul_res_lo = '0;
    logic [3:0]  mul_crf_hi = '0;
    logic [3:0]  mul_crf_lo = '0;
    logic        xer_so_wr = 1'b0;
    logic        xer_so_wdata = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        wb_cr_we;
    logic [3:0]  wb_crf;
    logic        wb_xer_we;
    logic        wb_xer_ov;
    logic        wb_xer_so;
    logic        busy;

    mul_writeback_stage #(.DWIDTH(32), .GPR_AW(5), .LATENCY(LAT), .FIFO_DEPTH(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_dest(issue_dest),
        .issue_sel_hi(issue_sel_hi), .issue_rc(issue_rc), .issue_oe(issue_oe),
        .mul_res_hi(mul_res_hi), .mul_res_lo(mul_res_lo),
        .mul_crf_hi(mul_crf_hi), .mul_crf_lo(mul_crf_lo),
        .xer_so_wr(xer_so_wr), .xer_so_wdata(xer_so_wdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest), .wb_data(wb_data),
        .wb_cr_we(wb_cr_we), .wb_crf(wb_crf), .wb_xer_we(wb_xer_we),
        .wb_xer_ov(wb_xer_ov), .wb_xer_so(wb_xer_so), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  dest;
        logic        sel_hi;
        logic        rc;
        logic        oe;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [3:0]  ch;
        logic [3:0]  cl;
        logic [31:0] edata;
        logic [3:0]  ecrf;
        logic        eov;
        logic        eso;
    } vec_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [3:0]  ch;
        logic [3:0]  cl;
    } prod_t;

    prod_t        pipe [LAT+1];
    logic [44:0]  exp_q [$];
    vec_t         tbl [12];
    int           checks = 0;
    int           failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Advances one clock and models the multiplier: products emerge LAT cycles after their issue cycle.
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = LAT; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0]     = '0;
        mul_res_hi  = pipe[LAT].hi;
        mul_res_lo  = pipe[LAT].lo;
        mul_crf_hi  = pipe[LAT].ch;
        mul_crf_lo  = pipe[LAT].cl;
        issue_valid = 1'b0;
        flush       = 1'b0;
        xer_so_wr   = 1'b0;
    endtask

    task automatic issue(input vec_t v, input bit keep);
        issue_valid  = 1'b1;
        issue_dest   = v.dest;
        issue_sel_hi = v.sel_hi;
        issue_rc     = v.rc;
        issue_oe     = v.oe;
        pipe[0]      = {v.hi, v.lo, v.ch, v.cl};
        #1;
        check("issue_ready", issue_ready, 1);
        if (keep) exp_q.push_back({v.dest, v.edata, v.ecrf, v.rc, v.oe, v.eov, v.eso});
        cycle();
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        #1;
        while (!wb_valid && n < 20) begin
            cycle();
            n++;
            #1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        #1;
        while (busy && n < 60) begin
            cycle();
            n++;
            #1;
        end
        check("drain_busy", busy, 0);
    endtask

    always @(negedge clk) begin
        if (!reset && wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected actual=dest %0d data %0h expected=no result", wb_dest, wb_data);
            end else begin
                check("wb_out", {wb_dest, wb_data, wb_crf, wb_cr_we, wb_xer_we, wb_xer_ov, wb_xer_so},
                      exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        vec_t v;
        //          dest  hi rc oe hi_word       lo_word       crf_h    crf_l    exp_data      exp_crf  ov    so
        tbl[0]  = '{5'd3, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, 4'b1000, 4'b1000, 32'hFFFFFFFA, 4'b1000, 1'b0, 1'b0};
        tbl[1]  = '{5'd7, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h0000000F, 4'b0010, 4'b0100, 32'h00000000, 4'b0010, 1'b0, 1'b0};
        tbl[2]  = '{5'd4, 1'b0, 1'b1, 1'b1, 32'h00000001, 32'h80000000, 4'b0100, 4'b1001, 32'h80000000, 4'b1001, 1'b1, 1'b1};
        tbl[3]  = '{5'd5, 1'b0, 1'b1, 1'b1, 32'h00000000, 32'h00000006, 4'b0010, 4'b0100, 32'h00000006, 4'b0101, 1'b0, 1'b1};
        tbl[4]  = '{5'd6, 1'b0, 1'b1, 1'b1, 32'h00000000, 32'h00000000, 4'b0010, 4'b0010, 32'h00000000, 4'b0010, 1'b0, 1'b0};
        tbl[5]  = '{5'd8, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 4'b1000, 4'b0101, 32'hFFFFFFFF, 4'b1000, 1'b0, 1'b0};
        tbl[6]  = '{5'd9, 1'b0, 1'b1, 1'b1, 32'h00000002, 32'h00000000, 4'b0100, 4'b0011, 32'h00000000, 4'b0011, 1'b1, 1'b1};
        tbl[7]  = '{5'd1, 1'b0, 1'b0, 1'b1, 32'h00000000, 32'h00000009, 4'b0010, 4'b0100, 32'h00000009, 4'b0100, 1'b0, 1'b0};
        tbl[8]  = '{5'd2, 1'b0, 1'b1, 1'b1, 32'h00000000, 32'h00000007, 4'b0010, 4'b0100, 32'h00000007, 4'b0101, 1'b0, 1'b1};
        tbl[9]  = '{5'd12, 1'b1, 1'b0, 1'b0, 32'h0000ABCD, 32'h12340000, 4'b0100, 4'b0100, 32'h0000ABCD, 4'b0101, 1'b0, 1'b1};
        tbl[10] = '{5'd13, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'hDEADBEEF, 4'b0010, 4'b1000, 32'hDEADBEEF, 4'b1001, 1'b0, 1'b1};
        tbl[11] = '{5'd31, 1'b0, 1'b1, 1'b1, 32'h00000000, 32'h00000005, 4'b0010, 4'b0100, 32'h00000005, 4'b0100, 1'b0, 1'b0};
        for (int i = 0; i <= LAT; i++) pipe[i] = '0;

        // Reset state
        cycle();
        cycle();
        #1;
        check("reset_outputs", {wb_valid, wb_dest, wb_data, wb_crf, wb_cr_we, wb_xer_we, wb_xer_ov, wb_xer_so, busy}, 0);
        check("reset_issue_ready", issue_ready, 1);
        reset    = 1'b0;
        wb_ready = 1'b1;

        // Signed mullw, lo word and issue-to-writeback latency
        issue(tbl[0], 1);
        wait_valid(lat);
        check("latency", lat, EXP_LAT);
        wait_idle();

        // mulhw record form
        issue(tbl[1], 1);
        wait_idle();

        // Sticky overflow, mtxer clear, hi-select never overflows
        issue(tbl[2], 1);
        issue(tbl[3], 1);
        wait_idle();
        xer_so_wr    = 1'b1;
        xer_so_wdata = 1'b0;
        cycle();
        issue(tbl[4], 1);
        issue(tbl[5], 1);
        wait_idle();

        // mtxer in the same cycle as an overflowing OE pop must win
        wb_ready = 1'b0;
        issue(tbl[6], 1);
        wait_valid(lat);
        check("ov_pending_valid", wb_valid, 1);
        wb_ready     = 1'b1;
        xer_so_wr    = 1'b1;
        xer_so_wdata = 1'b0;
        cycle();
        issue(tbl[7], 1);
        wait_idle();

        // Backpressure: exactly FIFO_DEPTH credits, then recovery on the first pop
        wb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            v = '{5'(10 + i), 1'b0, 1'b0, 1'b0, 32'h0, 32'h100 + 32'(i), 4'b0010, 4'b0100,
                  32'h100 + 32'(i), 4'b0100, 1'b0, 1'b0};
            issue(v, 1);
        end
        #1;
        check("credit_full", issue_ready, 0);
        for (int i = 0; i < LAT + 2; i++) begin
            issue_valid = 1'b1;
            issue_dest  = 5'd30;
            #1;
            check("credit_hold", issue_ready, 0);
            cycle();
        end
        wb_ready = 1'b1;
        #1;
        check("credit_pop", issue_ready, 1);
        cycle();
        wait_idle();

        // Flush with 3 in flight and 2 buffered; SO survives the flush
        xer_so_wr    = 1'b1;
        xer_so_wdata = 1'b1;
        cycle();
        wb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            v = '{5'(20 + i), 1'b0, 1'b0, 1'b0, 32'h0, 32'hBAD0 + 32'(i), 4'b0010, 4'b0100,
                  32'h0, 4'b0000, 1'b0, 1'b0};
            issue(v, 0);
        end
        cycle();
        #1;
        check("preflush_valid", wb_valid, 1);
        flush = 1'b1;
        cycle();
        #1;
        check("flush_valid", wb_valid, 0);
        check("flush_busy", busy, 0);
        check("flush_issue_ready", issue_ready, 1);
        for (int i = 0; i < LAT; i++) begin
            cycle();
            #1;
            check("flush_quiet", wb_valid, 0);
        end
        wb_ready = 1'b1;
        issue(tbl[8], 1);
        wait_idle();

        // Latency with ready, then a held result under backpressure
        issue(tbl[9], 1);
        wait_valid(lat);
        check("latency_ready", lat, EXP_LAT);
        wait_idle();
        wb_ready = 1'b0;
        issue(tbl[10], 1);
        wait_valid(lat);
        check("latency_held", lat, EXP_LAT);
        for (int i = 0; i < 3; i++) begin
            cycle();
            #1;
            check("hold_valid", wb_valid, 1);
        end
        wb_ready = 1'b1;
        wait_idle();

        // Reset mid-operation discards in-flight ops and clears SO
        v = tbl[9];
        issue(v, 0);
        issue(v, 0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        for (int i = 0; i < LAT + 1; i++) begin
            cycle();
            #1;
            check("midreset_quiet", wb_valid, 0);
        end
        issue(tbl[11], 1);
        wait_idle();

        cycle();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
